// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans four hex digits onto a common-anode 7-segment
// display, snapshotting q0..q3/dp_in once per frame so digits never tear.
//
// Parameters:
//   SCAN_DIV    clk cycles per digit slot (>= 8)
//   LZB         1 = blank leading zeros on digits 3..1
// Optional build macro:
//   SEG_GHOST_BLANK_EN  holds all anodes off for the first SCAN_DIV/8
//                       clks of each slot (anti-ghosting dead time)
// Ports:
//   clk, rst        clock, async active-low reset
//   q0..q3          digit values, q0 rightmost
//   dp_in           decimal-point request per digit, 1 = lit
//   an              anode enables, active-low one-hot
//   seg             segments {g,f,e,d,c,b,a}, active-low
//   dp              decimal point, active-low
//   frame_start     1-clk pulse when a new snapshot takes effect
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int LZB      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] q0,
    input  logic [3:0] q1,
    input  logic [3:0] q2,
    input  logic [3:0] q3,
    input  logic [3:0] dp_in,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic [1:0]    dig;
    logic [3:0]    snap_q0, snap_q1, snap_q2, snap_q3;
    logic [3:0]    snap_dp;
    logic          tick;
    logic          frame_end;

    logic [3:0]    cur_val;
    logic          raw_blank;
    logic          blank;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick      = (div_cnt == DIV_MAX);
    assign frame_end = tick && (dig == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            dig     <= 2'd0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                dig <= dig + 2'd1;
        end
    end

    // Snapshot lands on the same edge dig wraps to 0, so a frame
    // always starts on digit 0 with fresh values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q0 <= 4'd0;
            snap_q1 <= 4'd0;
            snap_q2 <= 4'd0;
            snap_q3 <= 4'd0;
            snap_dp <= 4'd0;
        end else if (frame_end) begin
            snap_q0 <= q0;
            snap_q1 <= q1;
            snap_q2 <= q2;
            snap_q3 <= q3;
            snap_dp <= dp_in;
        end
    end

    always_comb begin
        cur_val   = snap_q0;
        raw_blank = 1'b0;
        unique case (dig)
            2'd0: begin
                cur_val   = snap_q0;
                raw_blank = 1'b0;
            end
            2'd1: begin
                cur_val   = snap_q1;
                raw_blank = (snap_q3 | snap_q2 | snap_q1) == 4'd0;
            end
            2'd2: begin
                cur_val   = snap_q2;
                raw_blank = (snap_q3 | snap_q2) == 4'd0;
            end
            default: begin
                cur_val   = snap_q3;
                raw_blank = (snap_q3 == 4'd0);
            end
        endcase
        blank   = (LZB != 0) && raw_blank;
        seg_nxt = blank ? 7'h7F : hex7(cur_val);
        dp_nxt  = ~snap_dp[dig];
        an_nxt  = ~(4'b0001 << dig);
`ifdef SEG_GHOST_BLANK_EN
        if (div_cnt < CW'(SCAN_DIV / 8))
            an_nxt = 4'b1111;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an          <= 4'b1111;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver, SCAN_DIV=8,
// with an LZB=1 instance and an LZB=0 instance sharing the inputs.
module tb_seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [3:0] q0, q1, q2, q3, dp_in;
    logic [3:0] an, an_n;
    logic [6:0] seg, seg_n;
    logic       dp, dp_n;
    logic       frame_start, fs_n;

    int total;
    int bad;

`ifdef SEG_GHOST_BLANK_EN
    localparam logic [3:0] AN_FIRST = 4'b1111;
`else
    localparam logic [3:0] AN_FIRST = 4'b1110;
`endif

    seg_scan_driver #(.SCAN_DIV(8), .LZB(1)) dut (
        .clk(clk), .rst(rst),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .dp_in(dp_in),
        .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    seg_scan_driver #(.SCAN_DIV(8), .LZB(0)) dut_nz (
        .clk(clk), .rst(rst),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3), .dp_in(dp_in),
        .an(an_n), .seg(seg_n), .dp(dp_n), .frame_start(fs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 64);
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL wait_fs timeout got=%b want=1", frame_start);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        q3 = 4'd1; q2 = 4'd2; q1 = 4'd3; q0 = 4'd4;
        dp_in = 4'b0010;
        repeat (3) @(negedge clk);
        total += 4;
        if (an !== 4'b1111) begin bad++; $display("FAIL rst_an got=%b want=1111", an); end
        if (seg !== 7'h7F) begin bad++; $display("FAIL rst_seg got=%b want=1111111", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL rst_dp got=%b want=1", dp); end
        if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs got=%b want=0", frame_start); end
        rst = 1'b1;
        for (int c = 1; c <= 31; c++) begin
            @(negedge clk);
            total++;
            if (frame_start !== 1'b0) begin
                bad++; $display("FAIL early_fs c=%0d got=%b want=0", c, frame_start);
            end
            if (c == 1) begin
                total += 2;
                if (an !== AN_FIRST) begin bad++; $display("FAIL first_an got=%b want=%b", an, AN_FIRST); end
                if (seg !== 7'h40) begin bad++; $display("FAIL first_seg got=%b want=1000000", seg); end
            end
            if (c == 5 || c == 13 || c == 21 || c == 29) begin
                logic [3:0] ea;
                logic [6:0] es;
                ea = (c == 5) ? 4'b1110 : (c == 13) ? 4'b1101 : (c == 21) ? 4'b1011 : 4'b0111;
                es = (c == 5) ? 7'h40 : 7'h7F;
                total += 3;
                if (an !== ea) begin bad++; $display("FAIL scan_an c=%0d got=%b want=%b", c, an, ea); end
                if (seg !== es) begin bad++; $display("FAIL zero_seg c=%0d got=%b want=%b", c, seg, es); end
                if (dp !== 1'b1) begin bad++; $display("FAIL zero_dp c=%0d got=%b want=1", c, dp); end
            end
        end
    endtask

    task automatic test_snapshot();
        @(negedge clk);
        total += 2;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL fs_c32 got=%b want=1", frame_start); end
        if (fs_n !== 1'b1) begin bad++; $display("FAIL fs_n_c32 got=%b want=1", fs_n); end
        @(negedge clk);
        total += 3;
        if (frame_start !== 1'b0) begin bad++; $display("FAIL fs_width got=%b want=0", frame_start); end
        if (an !== AN_FIRST) begin bad++; $display("FAIL slot0_first_an got=%b want=%b", an, AN_FIRST); end
        if (seg !== 7'b0011001) begin bad++; $display("FAIL c33_seg got=%b want=0011001", seg); end
        repeat (4) @(negedge clk);
        total += 4;
        if (seg !== 7'b0011001) begin bad++; $display("FAIL d0_seg got=%b want=0011001", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL d0_dp got=%b want=1", dp); end
        if (an !== 4'b1110) begin bad++; $display("FAIL d0_an got=%b want=1110", an); end
        if (an_n !== 4'b1110) begin bad++; $display("FAIL d0_an_n got=%b want=1110", an_n); end
        repeat (8) @(negedge clk);
        total += 3;
        if (seg !== 7'b0110000) begin bad++; $display("FAIL d1_seg got=%b want=0110000", seg); end
        if (dp !== 1'b0) begin bad++; $display("FAIL d1_dp got=%b want=0", dp); end
        if (an !== 4'b1101) begin bad++; $display("FAIL d1_an got=%b want=1101", an); end
        repeat (8) @(negedge clk);
        total += 3;
        if (seg !== 7'b0100100) begin bad++; $display("FAIL d2_seg got=%b want=0100100", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL d2_dp got=%b want=1", dp); end
        if (an !== 4'b1011) begin bad++; $display("FAIL d2_an got=%b want=1011", an); end
    endtask

    task automatic test_tearing();
        q0 = 4'd9;
        q3 = 4'd8;
        repeat (8) @(negedge clk);
        total += 2;
        if (seg !== 7'b1111001) begin bad++; $display("FAIL tear_d3_seg got=%b want=1111001", seg); end
        if (an !== 4'b0111) begin bad++; $display("FAIL tear_d3_an got=%b want=0111", an); end
        q3 = 4'd1;
        repeat (3) @(negedge clk);
        total++;
        if (frame_start !== 1'b1) begin bad++; $display("FAIL fs_c64 got=%b want=1", frame_start); end
        repeat (5) @(negedge clk);
        total += 2;
        if (seg !== 7'b0010000) begin bad++; $display("FAIL tear_new_d0 got=%b want=0010000", seg); end
        if (an !== 4'b1110) begin bad++; $display("FAIL tear_new_an got=%b want=1110", an); end
    endtask

    task automatic test_lzb();
        int n;
        logic [6:0] e1 [4];
        logic [6:0] e0 [4];
        logic       ed [4];
        q3 = 4'd0; q2 = 4'd0; q1 = 4'd0; q0 = 4'd5;
        dp_in = 4'b1000;
        e1 = '{7'b0010010, 7'h7F, 7'h7F, 7'h7F};
        e0 = '{7'b0010010, 7'h40, 7'h40, 7'h40};
        ed = '{1'b1, 1'b1, 1'b1, 1'b0};
        wait_fs(n);
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 5 : 8) @(negedge clk);
            total += 3;
            if (seg !== e1[k]) begin bad++; $display("FAIL lzb5 d%0d got=%b want=%b", k, seg, e1[k]); end
            if (seg_n !== e0[k]) begin bad++; $display("FAIL nolzb5 d%0d got=%b want=%b", k, seg_n, e0[k]); end
            if (dp !== ed[k]) begin bad++; $display("FAIL lzb_dp d%0d got=%b want=%b", k, dp, ed[k]); end
        end
        q3 = 4'd0; q2 = 4'd7; q1 = 4'd0; q0 = 4'd0;
        dp_in = 4'b0000;
        e1 = '{7'h40, 7'h40, 7'b1111000, 7'h7F};
        e0 = '{7'h40, 7'h40, 7'b1111000, 7'h40};
        wait_fs(n);
        for (int k = 0; k < 4; k++) begin
            repeat ((k == 0) ? 5 : 8) @(negedge clk);
            total += 2;
            if (seg !== e1[k]) begin bad++; $display("FAIL lzb70 d%0d got=%b want=%b", k, seg, e1[k]); end
            if (seg_n !== e0[k]) begin bad++; $display("FAIL nolzb70 d%0d got=%b want=%b", k, seg_n, e0[k]); end
        end
    endtask

    task automatic test_hex();
        int n;
        q3 = 4'd0; q2 = 4'd0; q1 = 4'd0; q0 = 4'hA;
        wait_fs(n);
        @(negedge clk);
        total++;
        if (an !== AN_FIRST) begin bad++; $display("FAIL hex_first_an got=%b want=%b", an, AN_FIRST); end
        repeat (4) @(negedge clk);
        total += 2;
        if (seg !== 7'b0001000) begin bad++; $display("FAIL hex_A got=%b want=0001000", seg); end
        if (an !== 4'b1110) begin bad++; $display("FAIL hex_A_an got=%b want=1110", an); end
        q0 = 4'hF;
        wait_fs(n);
        repeat (5) @(negedge clk);
        total++;
        if (seg !== 7'b0001110) begin bad++; $display("FAIL hex_F got=%b want=0001110", seg); end
    endtask

    task automatic test_reset_mid();
        int n;
        q3 = 4'd3; q2 = 4'd2; q1 = 4'd1; q0 = 4'hF;
        dp_in = 4'b0100;
        wait_fs(n);
        repeat (21) @(negedge clk);
        total += 3;
        if (seg !== 7'b0100100) begin bad++; $display("FAIL mid_d2_seg got=%b want=0100100", seg); end
        if (dp !== 1'b0) begin bad++; $display("FAIL mid_d2_dp got=%b want=0", dp); end
        if (an !== 4'b1011) begin bad++; $display("FAIL mid_d2_an got=%b want=1011", an); end
        #2 rst = 1'b0;
        #1;
        total += 4;
        if (an !== 4'b1111) begin bad++; $display("FAIL async_an got=%b want=1111", an); end
        if (seg !== 7'h7F) begin bad++; $display("FAIL async_seg got=%b want=1111111", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL async_dp got=%b want=1", dp); end
        if (frame_start !== 1'b0) begin bad++; $display("FAIL async_fs got=%b want=0", frame_start); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total += 2;
        if (an !== AN_FIRST) begin bad++; $display("FAIL rel_an got=%b want=%b", an, AN_FIRST); end
        if (seg !== 7'h40) begin bad++; $display("FAIL rel_seg got=%b want=1000000", seg); end
        repeat (4) @(negedge clk);
        total += 2;
        if (seg !== 7'h40) begin bad++; $display("FAIL rel_d0_seg got=%b want=1000000", seg); end
        if (an !== 4'b1110) begin bad++; $display("FAIL rel_d0_an got=%b want=1110", an); end
        repeat (8) @(negedge clk);
        total += 2;
        if (seg !== 7'h7F) begin bad++; $display("FAIL rel_d1_seg got=%b want=1111111", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL rel_d1_dp got=%b want=1", dp); end
        wait_fs(n);
        total++;
        if (n !== 19) begin bad++; $display("FAIL rel_fs_delay got=%0d want=19", n); end
        repeat (5) @(negedge clk);
        total++;
        if (seg !== 7'b0001110) begin bad++; $display("FAIL rel_new_d0 got=%b want=0001110", seg); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        q0 = 4'd0; q1 = 4'd0; q2 = 4'd0; q3 = 4'd0;
        dp_in = 4'd0;
        test_reset();
        test_snapshot();
        test_tearing();
        test_lzb();
        test_hex();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
